// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing NUM_REGS writable/readable registers.
// SPI pins are oversampled by clk through 2-flop synchronisers plus an edge-detect flop.
module spi_regfile_peripheral #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCLK,
    input  logic                       nCS,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_q,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int SR_W      = ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_DATA0 = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_LEN + 1);

    // [0],[1]: synchroniser; [2]: edge-detect stage
    logic [2:0] sclk_sr;
    logic [2:0] ncs_sr;
    logic [2:0] copi_sr;

    logic sclk_rise, sclk_fall, ncs_fall, ncs_rise, ncs_low, copi_bit;

    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   sreg;
    logic [SR_W-1:0]   next_sreg;
    logic              rw;
    logic [DATA_W-1:0] oshift;
    logic [DATA_W-1:0] rd_val;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cmt_addr;
    logic [DATA_W-1:0] cmt_data;
    logic              addr_ok;
    logic              commit;
    logic              bad_len;

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= '0;
            ncs_sr  <= '1;
            copi_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], SCLK};
            ncs_sr  <= {ncs_sr[1:0], nCS};
            copi_sr <= {copi_sr[1:0], COPI};
        end
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign ncs_fall  = ~ncs_sr[1] & ncs_sr[2];
    assign ncs_rise  = ncs_sr[1] & ~ncs_sr[2];
    assign ncs_low   = ~ncs_sr[1];
    // Delayed one stage so data lines up with the registered SCLK edge
    assign copi_bit  = copi_sr[2];

    assign next_sreg = {sreg[SR_W-2:0], copi_bit};
    assign rd_addr   = next_sreg[ADDR_W-1:0];
    assign cmt_addr  = sreg[SR_W-1 -: ADDR_W];
    assign cmt_data  = sreg[DATA_W-1:0];
    assign addr_ok   = 32'(cmt_addr) < NUM_REGS;
    assign commit    = ncs_rise && (cnt == CNT_FULL) && rw && addr_ok;
    assign bad_len   = ncs_rise && (cnt != CNT_FULL);

    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(rd_addr) == k) rd_val = regs[k];
        end
    end

    always_comb begin
        regs_q = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_q[k*DATA_W +: DATA_W] = regs[k];
        end
    end

    // Read data is shifted out only after the first data-bit rising edge, so the
    // controller samples the MSB on the first data clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sreg   <= '0;
            rw     <= 1'b0;
            oshift <= '0;
            CIPO   <= 1'b0;
        end else if (ncs_fall) begin
            cnt    <= '0;
            sreg   <= '0;
            rw     <= 1'b0;
            oshift <= '0;
            CIPO   <= 1'b0;
        end else if (ncs_rise) begin
            oshift <= '0;
            CIPO   <= 1'b0;
        end else if (ncs_low && sclk_rise) begin
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
            if (cnt == '0) begin
                rw <= copi_bit;
            end else if (cnt < CNT_FULL) begin
                sreg <= next_sreg;
            end
            if (cnt == CNT_ADDR && !rw) begin
                oshift <= rd_val << 1;
                CIPO   <= rd_val[DATA_W-1];
            end
        end else if (ncs_low && sclk_fall && !rw && cnt > CNT_DATA0) begin
            CIPO   <= oshift[DATA_W-1];
            oshift <= oshift << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            cipo_oe   <= 1'b0;
            for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_stb    <= commit;
            frame_err <= bad_len;
            cipo_oe   <= ~ncs_sr[2];
            if (commit) wr_addr <= cmt_addr;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (commit && 32'(cmt_addr) == k) regs[k] <= cmt_data;
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: default instance plus a 12x16-bit, 4-bit-address instance.
module tb_spi_regfile_peripheral;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst_n, sclk, ncs, copi, sel;

    logic         cipo0, oe0, stb0_w, ferr0;
    logic [39:0]  regs_q0;
    logic [6:0]   wr_addr0;
    logic         cipo1, oe1, stb1_w, ferr1;
    logic [191:0] regs_q1;
    logic [3:0]   wr_addr1;

    int checks = 0, failures = 0;
    int stb_n0 = 0, err_n0 = 0, stb_n1 = 0, err_n1 = 0;
    logic [31:0] obs_wr0[$], exp_wr0[$], obs_wr1[$], exp_wr1[$];
    logic [15:0] exp_rd[$];
    logic [7:0]   model0 [5];
    logic [15:0]  model1 [12];
    logic [39:0]  exp_flat0;
    logic [191:0] exp_flat1;

    always #5 clk = ~clk;

    spi_regfile_peripheral dut0 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk), .nCS(ncs), .COPI(copi),
        .CIPO(cipo0), .cipo_oe(oe0), .regs_q(regs_q0), .wr_stb(stb0_w),
        .wr_addr(wr_addr0), .frame_err(ferr0)
    );

    spi_regfile_peripheral #(.NUM_REGS(12), .ADDR_W(4), .DATA_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk), .nCS(ncs), .COPI(copi),
        .CIPO(cipo1), .cipo_oe(oe1), .regs_q(regs_q1), .wr_stb(stb1_w),
        .wr_addr(wr_addr1), .frame_err(ferr1)
    );

    always_comb begin
        exp_flat0 = '0;
        for (int k = 0; k < 5; k++) exp_flat0[k*8 +: 8] = model0[k];
    end

    always_comb begin
        exp_flat1 = '0;
        for (int k = 0; k < 12; k++) exp_flat1[k*16 +: 16] = model1[k];
    end

    // Output monitor: records every write strobe with the register value it produced
    always @(negedge clk) begin
        if (stb0_w === 1'b1) begin
            stb_n0++;
            obs_wr0.push_back({16'(wr_addr0), 8'h00, regs_q0[int'(wr_addr0)*8 +: 8]});
        end
        if (ferr0 === 1'b1) err_n0++;
        if (stb1_w === 1'b1) begin
            stb_n1++;
            obs_wr1.push_back({16'(wr_addr1), regs_q1[int'(wr_addr1)*16 +: 16]});
        end
        if (ferr1 === 1'b1) err_n1++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input int n, input logic [63:0] tx, output logic [63:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            copi = tx[n-1-i];
            tick(HALF);
            sclk = 1'b1;
            rx = {rx[62:0], (sel ? cipo1 : cipo0)};
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_xfer(input int n, input logic [63:0] tx, output logic [63:0] rx);
        ncs = 1'b0;
        tick(HALF);
        shift_bits(n, tx, rx);
        tick(HALF);
        ncs = 1'b1;
        tick(3*HALF);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0; sel = 1'b0;
        for (int k = 0; k < 5; k++) model0[k] = '0;
        for (int k = 0; k < 12; k++) model1[k] = '0;
        tick(5);
        checks++; if (regs_q0 !== 40'h0) begin failures++; $display("FAIL reset_regs0 got=%h want=0", regs_q0); end
        checks++; if (regs_q1 !== 192'h0) begin failures++; $display("FAIL reset_regs1 got=%h want=0", regs_q1); end
        checks++; if (cipo0 !== 1'b0 || oe0 !== 1'b0) begin failures++; $display("FAIL reset_cipo got=%b/%b want=0/0", cipo0, oe0); end
        checks++; if (stb0_w !== 1'b0 || ferr0 !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b/%b want=0/0", stb0_w, ferr0); end
        checks++; if (wr_addr0 !== 7'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d want=0", wr_addr0); end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_write_reg2;
        logic [63:0] rx;
        logic [31:0] got, want;
        int s0 = stb_n0, e0 = err_n0;
        exp_wr0.push_back({16'd2, 16'h00A5});
        model0[2] = 8'hA5;
        spi_xfer(16, 64'({1'b1, 7'd2, 8'hA5}), rx);
        checks++; if (stb_n0 - s0 !== 1) begin failures++; $display("FAIL wr2_stb_count got=%0d want=1", stb_n0 - s0); end
        checks++;
        if (obs_wr0.size() == 0) begin failures++; $display("FAIL wr2_scoreboard got=none want=%h", exp_wr0[0]); exp_wr0.delete(); end
        else begin got = obs_wr0.pop_front(); want = exp_wr0.pop_front();
            if (got !== want) begin failures++; $display("FAIL wr2_scoreboard got=%h want=%h", got, want); end end
        checks++; if (regs_q0[23:16] !== 8'hA5) begin failures++; $display("FAIL wr2_reg2 got=%h want=a5", regs_q0[23:16]); end
        checks++; if (regs_q0 !== exp_flat0) begin failures++; $display("FAIL wr2_bank got=%h want=%h", regs_q0, exp_flat0); end
        checks++; if (wr_addr0 !== 7'd2) begin failures++; $display("FAIL wr2_wr_addr got=%0d want=2", wr_addr0); end
        checks++; if (err_n0 !== e0) begin failures++; $display("FAIL wr2_frame_err got=%0d want=%0d", err_n0, e0); end
    endtask

    task automatic test_read_back;
        logic [63:0] rx;
        logic [31:0] got, want;
        logic [15:0] rd_want;
        int s0, e0 = err_n0;
        exp_wr0.push_back({16'd4, 16'h003C});
        model0[4] = 8'h3C;
        spi_xfer(16, 64'({1'b1, 7'd4, 8'h3C}), rx);
        checks++;
        if (obs_wr0.size() == 0) begin failures++; $display("FAIL rb_write got=none want=%h", exp_wr0[0]); exp_wr0.delete(); end
        else begin got = obs_wr0.pop_front(); want = exp_wr0.pop_front();
            if (got !== want) begin failures++; $display("FAIL rb_write got=%h want=%h", got, want); end end
        s0 = stb_n0;
        exp_rd.push_back(16'h003C);
        ncs = 1'b0;
        tick(HALF);
        checks++; if (oe0 !== 1'b1) begin failures++; $display("FAIL rb_oe_active got=%b want=1", oe0); end
        shift_bits(16, 64'({1'b0, 7'd4, 8'h00}), rx);
        tick(HALF);
        ncs = 1'b1;
        tick(3*HALF);
        checks++; if (oe0 !== 1'b0) begin failures++; $display("FAIL rb_oe_idle got=%b want=0", oe0); end
        rd_want = exp_rd.pop_front();
        checks++; if (rx[7:0] !== rd_want[7:0]) begin failures++; $display("FAIL rb_data got=%h want=%h", rx[7:0], rd_want[7:0]); end
        checks++; if (regs_q0 !== exp_flat0 || stb_n0 !== s0) begin failures++; $display("FAIL rb_no_modify got=%h want=%h", regs_q0, exp_flat0); end
        checks++; if (err_n0 !== e0) begin failures++; $display("FAIL rb_frame_err got=%0d want=%0d", err_n0, e0); end
        checks++; if (cipo0 !== 1'b0) begin failures++; $display("FAIL rb_cipo_idle got=%b want=0", cipo0); end
    endtask

    task automatic test_out_of_range;
        logic [63:0] rx;
        logic [15:0] rd_want;
        int s0 = stb_n0, e0 = err_n0;
        spi_xfer(16, 64'({1'b1, 7'd5, 8'hFF}), rx);
        checks++; if (stb_n0 !== s0) begin failures++; $display("FAIL oor_write_stb got=%0d want=%0d", stb_n0, s0); end
        checks++; if (regs_q0 !== exp_flat0) begin failures++; $display("FAIL oor_bank got=%h want=%h", regs_q0, exp_flat0); end
        exp_rd.push_back(16'h0000);
        spi_xfer(16, 64'({1'b0, 7'd7, 8'h00}), rx);
        rd_want = exp_rd.pop_front();
        checks++; if (rx[7:0] !== rd_want[7:0]) begin failures++; $display("FAIL oor_read got=%h want=%h", rx[7:0], rd_want[7:0]); end
        checks++; if (err_n0 !== e0) begin failures++; $display("FAIL oor_frame_err got=%0d want=%0d", err_n0, e0); end
    endtask

    task automatic test_bad_length;
        logic [63:0] rx;
        int s0 = stb_n0, e0 = err_n0;
        spi_xfer(15, 64'({1'b1, 7'd1, 7'h3B}), rx);
        checks++; if (err_n0 - e0 !== 1) begin failures++; $display("FAIL bad15_err got=%0d want=1", err_n0 - e0); end
        spi_xfer(17, 64'({1'b1, 7'd1, 8'h77, 1'b1}), rx);
        checks++; if (err_n0 - e0 !== 2) begin failures++; $display("FAIL bad17_err got=%0d want=2", err_n0 - e0); end
        checks++; if (stb_n0 !== s0 || regs_q0 !== exp_flat0) begin failures++; $display("FAIL bad_no_commit got=%h want=%h", regs_q0, exp_flat0); end
    endtask

    task automatic test_abort_restart;
        logic [63:0] rx;
        logic [31:0] got, want;
        int s0 = stb_n0, e0 = err_n0;
        spi_xfer(6, 64'(6'b100000), rx);
        checks++; if (err_n0 - e0 !== 1 || stb_n0 !== s0) begin failures++; $display("FAIL abort_err got=%0d/%0d want=1/0", err_n0 - e0, stb_n0 - s0); end
        exp_wr0.push_back({16'd0, 16'h0011});
        model0[0] = 8'h11;
        spi_xfer(16, 64'({1'b1, 7'd0, 8'h11}), rx);
        checks++;
        if (obs_wr0.size() == 0) begin failures++; $display("FAIL restart_commit got=none want=%h", exp_wr0[0]); exp_wr0.delete(); end
        else begin got = obs_wr0.pop_front(); want = exp_wr0.pop_front();
            if (got !== want) begin failures++; $display("FAIL restart_commit got=%h want=%h", got, want); end end
        checks++; if (regs_q0 !== exp_flat0 || err_n0 - e0 !== 1) begin failures++; $display("FAIL restart_bank got=%h want=%h", regs_q0, exp_flat0); end
    endtask

    task automatic test_reset_midframe;
        logic [63:0] rx;
        int s0 = stb_n0, e0 = err_n0;
        ncs = 1'b0;
        tick(HALF);
        shift_bits(10, 64'({1'b1, 7'd3, 2'b10}), rx);
        rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        for (int k = 0; k < 5; k++) model0[k] = '0;
        for (int k = 0; k < 12; k++) model1[k] = '0;
        tick(3);
        checks++; if (regs_q0 !== 40'h0 || regs_q1 !== 192'h0) begin failures++; $display("FAIL rstmid_regs got=%h want=0", regs_q0); end
        checks++; if (cipo0 !== 1'b0 || oe0 !== 1'b0 || stb0_w !== 1'b0 || ferr0 !== 1'b0 || wr_addr0 !== 7'd0) begin
            failures++; $display("FAIL rstmid_outputs got=%b%b%b%b/%0d want=0000/0", cipo0, oe0, stb0_w, ferr0, wr_addr0); end
        rst_n = 1'b1;
        tick(4*HALF);
        checks++; if (stb_n0 !== s0 || err_n0 !== e0 || regs_q0 !== exp_flat0) begin
            failures++; $display("FAIL rstmid_no_commit got=%0d/%0d want=%0d/%0d", stb_n0, err_n0, s0, e0); end
    endtask

    task automatic test_param_wide;
        logic [63:0] rx;
        logic [31:0] got, want;
        logic [15:0] rd_want;
        int s1 = stb_n1, e1 = err_n1;
        sel = 1'b1;
        exp_wr1.push_back({16'd11, 16'hBEEF});
        model1[11] = 16'hBEEF;
        spi_xfer(21, 64'({1'b1, 4'd11, 16'hBEEF}), rx);
        checks++;
        if (obs_wr1.size() == 0) begin failures++; $display("FAIL p_write got=none want=%h", exp_wr1[0]); exp_wr1.delete(); end
        else begin got = obs_wr1.pop_front(); want = exp_wr1.pop_front();
            if (got !== want) begin failures++; $display("FAIL p_write got=%h want=%h", got, want); end end
        checks++; if (wr_addr1 !== 4'd11 || stb_n1 - s1 !== 1) begin failures++; $display("FAIL p_wr_addr got=%0d want=11", wr_addr1); end
        checks++; if (regs_q1 !== exp_flat1) begin failures++; $display("FAIL p_bank got=%h want=%h", regs_q1, exp_flat1); end
        exp_rd.push_back(16'hBEEF);
        spi_xfer(21, 64'({1'b0, 4'd11, 16'h0000}), rx);
        rd_want = exp_rd.pop_front();
        checks++; if (rx[15:0] !== rd_want) begin failures++; $display("FAIL p_read got=%h want=%h", rx[15:0], rd_want); end
        spi_xfer(21, 64'({1'b1, 4'd12, 16'h1234}), rx);
        checks++; if (stb_n1 - s1 !== 1 || regs_q1 !== exp_flat1) begin failures++; $display("FAIL p_oor got=%0d want=1", stb_n1 - s1); end
        checks++; if (err_n1 !== e1) begin failures++; $display("FAIL p_frame_err got=%0d want=%0d", err_n1, e1); end
        sel = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_write_reg2;
        test_read_back;
        test_out_of_range;
        test_bad_length;
        test_abort_restart;
        test_reset_midframe;
        test_param_wide;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
